// File: rtl/reg_file_alu_ctrl.sv
// Three-cycle sequencer (IDLE -> DECODE -> EXEC) that drives the control inputs of reg_file_alu.
// Optional macro CTRL_ZERO_REG_PROTECT_EN makes register 0 read-only.
module reg_file_alu_ctrl #(
   parameter int INSTR_W = 20,
   parameter int CNT_W   = 16
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [INSTR_W-1:0] instr,
   input  logic               instr_valid,
   output logic               instr_ready,
   output logic [3:0]         RA1,
   output logic [3:0]         RA2,
   output logic [3:0]         WA,
   output logic [7:0]         immediate,
   output logic [1:0]         ALUControl,
   output logic               ALUSrc,
   output logic               write_enable,
   input  logic [7:0]         ALUResult,
   input  logic               Zero,
   output logic [7:0]         result_q,
   output logic               zero_flag,
   output logic               done,
   output logic               halted,
   output logic [CNT_W-1:0]   instr_count
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DECODE = 2'd1;
   localparam logic [1:0] ST_EXEC   = 2'd2;
   localparam logic [1:0] ST_HALT   = 2'd3;

   localparam logic [1:0] OP_RTYPE = 2'b00;
   localparam logic [1:0] OP_ITYPE = 2'b01;
   localparam logic [1:0] OP_CMP   = 2'b10;
   localparam logic [1:0] OP_HALT  = 2'b11;

   logic [1:0]       state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [3:0]       ra1_q, ra1_d;
   logic [3:0]       ra2_q, ra2_d;
   logic [3:0]       wa_q, wa_d;
   logic [7:0]       imm_q, imm_d;
   logic [1:0]       alu_q, alu_d;
   logic             src_q, src_d;
   logic             we_q, we_d;
   logic             done_q, done_d;
   logic [7:0]       res_q, res_d;
   logic             zero_q, zero_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wr_ok;

   always_comb begin
      wr_ok = (op_q == OP_RTYPE) || (op_q == OP_ITYPE);
`ifdef CTRL_ZERO_REG_PROTECT_EN
      wr_ok = wr_ok && (wa_q != 4'd0);
`endif
   end

   // Decoded fields are registered on the handshake edge so they are already valid in DECODE.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      ra1_d   = ra1_q;
      ra2_d   = ra2_q;
      wa_d    = wa_q;
      imm_d   = imm_q;
      alu_d   = alu_q;
      src_d   = src_q;
      we_d    = 1'b0;
      done_d  = 1'b0;
      res_d   = res_q;
      zero_d  = zero_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (instr_valid) begin
               if (instr[19:18] == OP_HALT) begin
                  state_d = ST_HALT;
                  done_d  = 1'b1;
                  cnt_d   = cnt_q + CNT_W'(1);
               end else begin
                  state_d = ST_DECODE;
                  op_d    = instr[19:18];
                  alu_d   = instr[17:16];
                  wa_d    = instr[15:12];
                  ra1_d   = instr[11:8];
                  ra2_d   = instr[3:0];
                  imm_d   = instr[7:0];
                  src_d   = (instr[19:18] == OP_ITYPE);
               end
            end
         end
         ST_DECODE: begin
            state_d = ST_EXEC;
            we_d    = wr_ok;
         end
         ST_EXEC: begin
            state_d = ST_IDLE;
            res_d   = ALUResult;
            zero_d  = Zero;
            done_d  = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         op_q    <= OP_CMP;
         ra1_q   <= '0;
         ra2_q   <= '0;
         wa_q    <= '0;
         imm_q   <= '0;
         alu_q   <= '0;
         src_q   <= 1'b0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         ra1_q   <= ra1_d;
         ra2_q   <= ra2_d;
         wa_q    <= wa_d;
         imm_q   <= imm_d;
         alu_q   <= alu_d;
         src_q   <= src_d;
         we_q    <= we_d;
         done_q  <= done_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         cnt_q   <= cnt_d;
      end
   end

   assign instr_ready  = (state_q == ST_IDLE);
   assign halted       = (state_q == ST_HALT);
   assign RA1          = ra1_q;
   assign RA2          = ra2_q;
   assign WA           = wa_q;
   assign immediate    = imm_q;
   assign ALUControl   = alu_q;
   assign ALUSrc       = src_q;
   assign write_enable = we_q;
   assign result_q     = res_q;
   assign zero_flag    = zero_q;
   assign done         = done_q;
   assign instr_count  = cnt_q;

endmodule

// File: tb/tb_reg_file_alu_ctrl.sv
// Bench for reg_file_alu_ctrl: a behavioural register file/ALU closes the loop, and an
// instruction-level model predicts every observable result.
module tb_reg_file_alu_ctrl;

   localparam int CW = 4;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [19:0]   instr = '0;
   logic          instr_valid = 1'b0;
   logic          instr_ready;
   logic [3:0]    RA1, RA2, WA;
   logic [7:0]    immediate;
   logic [1:0]    ALUControl;
   logic          ALUSrc, write_enable;
   logic [7:0]    ALUResult;
   logic          Zero;
   logic [7:0]    result_q;
   logic          zero_flag, done, halted;
   logic [CW-1:0] instr_count;

   int checks = 0;
   int failures = 0;

   reg_file_alu_ctrl #(.INSTR_W(20), .CNT_W(CW)) dut (
      .CLK(CLK), .RST(RST), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .RA1(RA1), .RA2(RA2), .WA(WA), .immediate(immediate), .ALUControl(ALUControl),
      .ALUSrc(ALUSrc), .write_enable(write_enable), .ALUResult(ALUResult), .Zero(Zero),
      .result_q(result_q), .zero_flag(zero_flag), .done(done), .halted(halted),
      .instr_count(instr_count)
   );

   always #5 CLK = ~CLK;

   // Datapath stand-in: register file plus ALU (00 add, 01 sub, 10 and, 11 or).
   logic [7:0] hw_regs [16];
   logic [7:0] alu_a, alu_b;
   initial for (int i = 0; i < 16; i++) hw_regs[i] = 8'd0;
   always @(posedge CLK) if (write_enable) hw_regs[WA] <= ALUResult;
   always_comb begin
      alu_a = hw_regs[RA1];
      alu_b = ALUSrc ? immediate : hw_regs[RA2];
      case (ALUControl)
         2'b00:   ALUResult = alu_a + alu_b;
         2'b01:   ALUResult = alu_a - alu_b;
         2'b10:   ALUResult = alu_a & alu_b;
         default: ALUResult = alu_a | alu_b;
      endcase
      Zero = (ALUResult == 8'd0);
   end

   // Instruction-level reference state.
   int m_regs [16];
   int m_cnt = 0;
   int m_res = 0;
   int m_zero = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0;
      m_res = 0;
      m_zero = 0;
   endtask

   task automatic run_instr(input logic [19:0] ins, input string tag);
      int op, alu, wa, ra1, ra2, imm, a, b, r, we;
      op = int'(ins[19:18]); alu = int'(ins[17:16]); wa = int'(ins[15:12]);
      ra1 = int'(ins[11:8]); ra2 = int'(ins[3:0]); imm = int'(ins[7:0]);
      a = m_regs[ra1];
      b = (op == 1) ? imm : m_regs[ra2];
      case (alu)
         0: r = (a + b) % 256;
         1: r = (a - b + 256) % 256;
         2: r = a & b;
         default: r = a | b;
      endcase
      we = (op != 2) ? 1 : 0;
`ifdef CTRL_ZERO_REG_PROTECT_EN
      if (wa == 0) we = 0;
`endif
      @(negedge CLK);
      check({tag, ".ready_in"}, instr_ready, 1);
      instr = ins;
      instr_valid = 1'b1;
      @(negedge CLK);
      instr_valid = 1'b0;
      check({tag, ".dec_ra1"}, RA1, ra1);
      check({tag, ".dec_ra2"}, RA2, ra2);
      check({tag, ".dec_wa"}, WA, wa);
      check({tag, ".dec_alu"}, ALUControl, alu);
      check({tag, ".dec_src"}, ALUSrc, (op == 1));
      if (op == 1) check({tag, ".dec_imm"}, immediate, imm);
      check({tag, ".dec_we"}, write_enable, 0);
      check({tag, ".dec_ready"}, instr_ready, 0);
      @(negedge CLK);
      check({tag, ".exe_we"}, write_enable, we);
      check({tag, ".exe_ra1"}, RA1, ra1);
      check({tag, ".exe_ready"}, instr_ready, 0);
      check({tag, ".exe_done"}, done, 0);
      m_res = r;
      m_zero = (r == 0) ? 1 : 0;
      m_cnt = (m_cnt + 1) % (1 << CW);
      if (we != 0) m_regs[wa] = r;
      @(negedge CLK);
      check({tag, ".ret_done"}, done, 1);
      check({tag, ".ret_res"}, result_q, m_res);
      check({tag, ".ret_zero"}, zero_flag, m_zero);
      check({tag, ".ret_cnt"}, instr_count, m_cnt);
      check({tag, ".ret_we"}, write_enable, 0);
      check({tag, ".ret_ready"}, instr_ready, 1);
      check({tag, ".ret_reg"}, hw_regs[wa], m_regs[wa]);
   endtask

   task automatic reset_checks(input string tag);
      check({tag, ".ready"}, instr_ready, 1);
      check({tag, ".we"}, write_enable, 0);
      check({tag, ".res"}, result_q, 0);
      check({tag, ".zero"}, zero_flag, 0);
      check({tag, ".cnt"}, instr_count, 0);
      check({tag, ".halted"}, halted, 0);
      check({tag, ".done"}, done, 0);
   endtask

   initial begin
      logic [19:0] w;
      for (int i = 0; i < 16; i++) m_regs[i] = 0;
      model_reset();

      // Reset state
      @(negedge CLK);
      reset_checks("rst_hold");
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      reset_checks("rst_rel");

      // I-type: r3 = r0 + 5
      run_instr({2'b01, 2'b00, 4'd3, 4'd0, 8'h05}, "itype");
      // R-type: r5 = r3 + r3
      run_instr({2'b00, 2'b00, 4'd5, 4'd3, 8'h03}, "rtype");
      check("rtype_r5", hw_regs[5], 10);
      // CMP r3 - r3
      run_instr({2'b10, 2'b01, 4'd7, 4'd3, 8'h03}, "cmp_eq");
      check("cmp_zero", zero_flag, 1);
      check("cmp_r7", hw_regs[7], 0);

      // Randomized mix of R/I/CMP
      for (int n = 0; n < 24; n++) begin
         w = 20'($urandom);
         if (w[19:18] == 2'b11) w[19:18] = 2'($urandom_range(0, 2));
         run_instr(w, "rand");
      end

      // Writes to register 0
      run_instr({2'b01, 2'b00, 4'd0, 4'd9, 8'h3C}, "wa0");

      // Async reset during EXEC
      @(negedge CLK);
      instr = {2'b01, 2'b11, 4'd6, 4'd2, 8'hA5};
      instr_valid = 1'b1;
      @(negedge CLK);
      instr_valid = 1'b0;
      @(negedge CLK);
      check("mid_exec_we", write_enable, 1);
      #1 RST = 1'b1;
      #1;
      check("mid_rst_we", write_enable, 0);
      model_reset();
      reset_checks("mid_rst");
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
      check("mid_rst_r6", hw_regs[6], m_regs[6]);
      run_instr({2'b00, 2'b10, 4'd8, 4'd5, 8'h03}, "post_rst");

      // HALT, then an ignored I-type offer
      @(negedge CLK);
      instr = {2'b11, 18'd0};
      instr_valid = 1'b1;
      m_cnt = (m_cnt + 1) % (1 << CW);
      @(negedge CLK);
      instr = {2'b01, 2'b00, 4'd4, 4'd0, 8'h11};
      check("halt_halted", halted, 1);
      check("halt_done", done, 1);
      check("halt_ready", instr_ready, 0);
      check("halt_cnt", instr_count, m_cnt);
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         check("halt_hold", halted, 1);
         check("halt_ready_hold", instr_ready, 0);
         check("halt_we", write_enable, 0);
         check("halt_done_once", done, 0);
         check("halt_cnt_hold", instr_count, m_cnt);
      end
      instr_valid = 1'b0;
      RST = 1'b1;
      #1;
      model_reset();
      reset_checks("halt_rst");
      @(negedge CLK);
      RST = 1'b0;
      check("halt_r4", hw_regs[4], m_regs[4]);

      // Counter wrap past 2^CW - 1
      for (int n = 0; n < (1 << CW) + 2; n++) begin
         w = 20'($urandom);
         w[19:18] = 2'($urandom_range(0, 2));
         run_instr(w, "wrap");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/reg_file_alu_ctrl.md
Name: reg_file_alu_ctrl

Overview:
Multi-cycle sequencer that drives the control inputs of reg_file_alu. It accepts one 20-bit instruction per valid/ready handshake and decodes it into read/write addresses, an immediate, ALUControl and ALUSrc. It pulses write_enable for exactly one cycle and captures ALUResult and Zero, giving a small CPU core a single, race-free point of control over the register file and ALU.

Parameters:
INSTR_W, 20, instruction width; fields fixed as below, other values unsupported
CNT_W, 16, width of retired-instruction counter

Ports:
CLK  in  1  rising-edge clock
RST  in  1  reset, asynchronous, active-high
instr  in  INSTR_W  instruction word
instr_valid  in  1  instruction offered
instr_ready  out  1  controller can accept
RA1  out  4  read address 1 to reg file
RA2  out  4  read address 2 to reg file
WA  out  4  write address to reg file
immediate  out  8  immediate operand
ALUControl  out  2  ALU operation select
ALUSrc  out  1  0 = RD2, 1 = immediate
write_enable  out  1  reg file write strobe
ALUResult  in  8  ALU result from datapath
Zero  in  1  ALU zero flag from datapath
result_q  out  8  last captured ALUResult
zero_flag  out  1  last captured Zero
done  out  1  one-cycle pulse per retired instruction
halted  out  1  HALT executed
instr_count  out  CNT_W  retired-instruction count

Behaviour:
- Instruction fields: op[19:18], alu[17:16], wa[15:12], ra1[11:8], imm/ra2[7:0]; ra2 = instr[3:0].
- Opcodes: 00 R-type (ALUSrc=0, write); 01 I-type (ALUSrc=1, immediate=instr[7:0], write); 10 CMP (ALUSrc=0, no write, flags only); 11 HALT.
- FSM states: IDLE, DECODE, EXEC, HALT.
- IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instr. Go to HALT if op=11, else DECODE.
- DECODE: one cycle. RA1/RA2/WA/immediate/ALUControl/ALUSrc are registered and driven from the latched instruction; write_enable=0. The reg file read path and ALU settle in this cycle.
- EXEC: one cycle. Address and control outputs hold; write_enable=1 only for R/I-type. At the closing edge, result_q<=ALUResult, zero_flag<=Zero, done pulses the next cycle, instr_count increments. Then go to IDLE.
- Latency: handshake edge at cycle 0, DECODE cycle 1, EXEC cycle 2, register written at the end of cycle 2, instr_ready high again in cycle 3. Throughput is one instruction per 3 cycles.
- instr_ready=0 in DECODE/EXEC/HALT; instr_valid is ignored in those states and the offered instr must be held by the source.
- HALT: halted=1, instr_ready=0, write_enable=0. Leaves only on RST. HALT increments instr_count and pulses done once on entry.
- CMP never asserts write_enable but still updates result_q/zero_flag.
- Address/control outputs hold their last value in IDLE; write_enable is never high outside EXEC.
- instr_count wraps from 2^CNT_W-1 to 0.
- Reset (async, any state including mid-EXEC): state=IDLE; every output 0 except instr_ready=1; write_enable drops immediately without waiting for CLK.

Optional Feature:
CTRL_ZERO_REG_PROTECT_EN:
- Defined: register 0 is read-only. R/I-type with wa=0 suppresses write_enable in EXEC but still captures result_q/zero_flag and counts as retired.
- Undefined: wa=0 writes normally.

Test Plan:
1. RST high then low -> instr_ready=1, write_enable=0, result_q=0, instr_count=0, halted=0.
2. I-type op=01 alu=00 wa=3 imm=0x05, valid for 1 cycle -> ALUSrc=1, immediate=5, WA=3; write_enable high only in cycle 2; done in cycle 3; instr_count=1.
3. R-type wa=5 ra1=3 ra2=3 with reg3=5 and alu=add -> RA1=3, RA2=3, ALUSrc=0; after retire result_q=10, reg5 reads 10.
4. CMP on two equal registers with ALUControl=subtract -> write_enable stays 0 throughout; zero_flag=1.
5. HALT, then valid I-type -> halted=1, instr_ready stays 0, no write_enable; RST recovers to IDLE.
6. Assert RST during EXEC of an I-type -> write_enable falls before next CLK edge, state IDLE, instr_count=0; with CTRL_ZERO_REG_PROTECT_EN defined, I-type wa=0 -> no write_enable, done pulses.
